// File: rtl/interrupt_controller.sv
// Priority interrupt controller: rising-edge request capture, maskable pending bits, RST-n vectoring.
// Define INTC_TIMER_EN to add a periodic timer that raises the highest-numbered channel.
module interrupt_controller #(
    parameter int NUM_CH       = 8,
    parameter int TIMER_PERIOD = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] irq_in,
    input  logic              mask_we,
    input  logic [NUM_CH-1:0] mask_wdata,
    input  logic              inta,
    output logic              interrupt,
    output logic [23:0]       interrupt_instruction,
    output logic [2:0]        active_ch,
    output logic [NUM_CH-1:0] pending
);

    localparam logic [23:0] IDLE_INSTR = 24'hFF0000;
    localparam bit PARAMS_OK = (NUM_CH >= 1) && (NUM_CH <= 8) &&
                               (TIMER_PERIOD >= 2) && (TIMER_PERIOD <= 256);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t            state_r;
    logic [NUM_CH-1:0] irq_prev_r;
    logic [NUM_CH-1:0] pending_r;
    logic [NUM_CH-1:0] mask_r;
    logic [2:0]        active_ch_r;
    logic              interrupt_r;
    logic [23:0]       instr_r;

    logic [NUM_CH-1:0] edge_s;
    logic [NUM_CH-1:0] timer_hit_s;
    logic [NUM_CH-1:0] set_s;
    logic [NUM_CH-1:0] clr_s;
    logic [NUM_CH-1:0] eligible_s;

    generate
        if (!PARAMS_OK) begin : g_param_check
            $error("interrupt_controller: NUM_CH or TIMER_PERIOD out of range");
        end
    endgenerate

    // Lowest set index wins: bit 0 is the highest priority.
    function automatic logic [2:0] lowest_set(input logic [NUM_CH-1:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [23:0] rst_instr(input logic [2:0] ch);
        return {2'b11, ch, 3'b111, 16'h0000};
    endfunction

`ifdef INTC_TIMER_EN
    localparam int CNT_W = $clog2(TIMER_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMER_PERIOD - 1);

    logic [CNT_W-1:0] timer_cnt_r;

    // Free-running period counter, wrapping at TIMER_PERIOD-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_cnt_r <= '0;
        end else if (timer_cnt_r == CNT_LAST) begin
            timer_cnt_r <= '0;
        end else begin
            timer_cnt_r <= timer_cnt_r + CNT_W'(1);
        end
    end

    // Timer expiry shares the top channel with its external request line.
    always_comb begin
        timer_hit_s = '0;
        if (timer_cnt_r == CNT_LAST) begin
            timer_hit_s[NUM_CH-1] = 1'b1;
        end else begin
            timer_hit_s = '0;
        end
    end
`else
    assign timer_hit_s = '0;
`endif

    // Edge detection, set/clear vectors and the set of requests allowed to interrupt.
    always_comb begin
        edge_s     = irq_in & ~irq_prev_r;
        set_s      = edge_s | timer_hit_s;
        eligible_s = pending_r & ~mask_r;
        clr_s      = '0;
        if ((state_r == ST_REQ) && inta) begin
            clr_s[active_ch_r] = 1'b1;
        end else begin
            clr_s = '0;
        end
    end

    // Request history and pending register; a coincident set beats the acknowledge clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_prev_r <= '0;
            pending_r  <= '0;
        end else begin
            irq_prev_r <= irq_in;
            pending_r  <= (pending_r & ~clr_s) | set_s;
        end
    end

    // Mask register; masking only gates eligibility, never pending state.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_r <= '0;
        end else if (mask_we) begin
            mask_r <= mask_wdata;
        end else begin
            mask_r <= mask_r;
        end
    end

    // Request FSM with registered CPU-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            active_ch_r <= 3'd0;
            interrupt_r <= 1'b0;
            instr_r     <= IDLE_INSTR;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|eligible_s) begin
                        state_r     <= ST_REQ;
                        active_ch_r <= lowest_set(eligible_s);
                        interrupt_r <= 1'b1;
                        instr_r     <= rst_instr(lowest_set(eligible_s));
                    end else begin
                        state_r     <= ST_IDLE;
                        active_ch_r <= active_ch_r;
                        interrupt_r <= 1'b0;
                        instr_r     <= IDLE_INSTR;
                    end
                end
                ST_REQ: begin
                    // The granted channel is held until acknowledged, whatever else arrives.
                    if (inta) begin
                        state_r     <= ST_IDLE;
                        active_ch_r <= active_ch_r;
                        interrupt_r <= 1'b0;
                        instr_r     <= IDLE_INSTR;
                    end else begin
                        state_r     <= ST_REQ;
                        active_ch_r <= active_ch_r;
                        interrupt_r <= 1'b1;
                        instr_r     <= instr_r;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    active_ch_r <= 3'd0;
                    interrupt_r <= 1'b0;
                    instr_r     <= IDLE_INSTR;
                end
            endcase
        end
    end

    assign interrupt             = interrupt_r;
    assign interrupt_instruction = instr_r;
    assign active_ch             = active_ch_r;
    assign pending               = pending_r;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the controller.
module tb_interrupt_controller;

    localparam int NCH = 8;
    localparam int TP  = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  irq_in;
    logic        mask_we;
    logic [7:0]  mask_wdata;
    logic        inta;
    logic        interrupt;
    logic [23:0] interrupt_instruction;
    logic [2:0]  active_ch;
    logic [7:0]  pending;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [7:0] m_pend;
    logic [7:0] m_mask;
    logic [7:0] m_prev;
    bit         m_req;
    int         m_ch;
    int         m_tcnt;

    interrupt_controller #(.NUM_CH(NCH), .TIMER_PERIOD(TP)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .irq_in                (irq_in),
        .mask_we               (mask_we),
        .mask_wdata            (mask_wdata),
        .inta                  (inta),
        .interrupt             (interrupt),
        .interrupt_instruction (interrupt_instruction),
        .active_ch             (active_ch),
        .pending               (pending)
    );

    always #5 clk = ~clk;

    task automatic lit(input string name, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // One clock edge of the model, using the inputs presented at that edge.
    task automatic model_step();
        logic [7:0] nxt;
        int pick;
        if (rst) begin
            m_pend = 8'h00; m_mask = 8'h00; m_prev = 8'h00;
            m_req = 1'b0; m_ch = 0; m_tcnt = 0;
        end else begin
            nxt = m_pend;
            if (m_req && inta) nxt[m_ch] = 1'b0;
            for (int i = 0; i < NCH; i++)
                if (irq_in[i] && !m_prev[i]) nxt[i] = 1'b1;
`ifdef INTC_TIMER_EN
            if (m_tcnt == TP - 1) nxt[NCH-1] = 1'b1;
            m_tcnt = (m_tcnt + 1) % TP;
`endif
            if (m_req) begin
                if (inta) m_req = 1'b0;
            end else begin
                pick = -1;
                for (int i = NCH - 1; i >= 0; i--)
                    if (m_pend[i] && !m_mask[i]) pick = i;
                if (pick >= 0) begin
                    m_req = 1'b1;
                    m_ch  = pick;
                end
            end
            m_pend = nxt;
            m_prev = irq_in;
            if (mask_we) m_mask = mask_wdata;
        end
    endtask

    function automatic logic [23:0] exp_instr();
        if (m_req) return 24'hC70000 + 24'(m_ch) * 24'h080000;
        return 24'hFF0000;
    endfunction

    task automatic compare();
        lit("interrupt", {23'd0, interrupt}, {23'd0, m_req});
        lit("instruction", interrupt_instruction, exp_instr());
        lit("active_ch", {21'd0, active_ch}, {21'd0, 3'(m_ch)});
        lit("pending", {16'd0, pending}, {16'd0, m_pend});
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        rst = 1'b1; irq_in = 8'h00; mask_we = 1'b0; mask_wdata = 8'h00; inta = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int first_rise;
        int second_rise;
        logic [23:0] rise_instr;
        logic prev_int;

        // Reset state and single request on channel 3, including set-beats-clear.
        do_reset();
        lit("rst_interrupt", {23'd0, interrupt}, 24'd0);
        lit("rst_instr", interrupt_instruction, 24'hFF0000);
        lit("rst_pending", {16'd0, pending}, 24'h0);
        lit("rst_active", {21'd0, active_ch}, 24'h0);
        irq_in = 8'h08; tick();
        lit("c3_pending", {16'd0, pending}, 24'h08);
        lit("c3_model_pend", {16'd0, m_pend}, 24'h08);
        lit("c3_int_early", {23'd0, interrupt}, 24'd0);
        tick();
        lit("c3_interrupt", {23'd0, interrupt}, 24'd1);
        lit("c3_instr", interrupt_instruction, 24'hDF0000);
        lit("c3_model_instr", exp_instr(), 24'hDF0000);
        irq_in = 8'h00; tick();
        irq_in = 8'h08; inta = 1'b1; tick();
        lit("setwin_int", {23'd0, interrupt}, 24'd0);
        lit("setwin_pend", {16'd0, pending}, 24'h08);
        inta = 1'b0; tick();
        lit("setwin_rereq", {23'd0, interrupt}, 24'd1);
        inta = 1'b1; tick();
        lit("c3_cleared", {16'd0, pending}, 24'h00);
        inta = 1'b0; tick();

        // Simultaneous channels 5 and 2: priority, then one idle cycle before channel 5.
        do_reset();
        irq_in = 8'h24; tick();
        lit("p_pending", {16'd0, pending}, 24'h24);
        tick();
        lit("p_active2", {21'd0, active_ch}, 24'd2);
        lit("p_instr2", interrupt_instruction, 24'hD70000);
        inta = 1'b1; tick();
        lit("p_gap_int", {23'd0, interrupt}, 24'd0);
        lit("p_gap_pend", {16'd0, pending}, 24'h20);
        inta = 1'b0; tick();
        lit("p_active5", {21'd0, active_ch}, 24'd5);
        lit("p_instr5", interrupt_instruction, 24'hEF0000);
        inta = 1'b1; tick();
        inta = 1'b0;

        // Masked request stays pending until unmasked.
        do_reset();
        mask_we = 1'b1; mask_wdata = 8'h01; tick();
        mask_we = 1'b0; irq_in = 8'h01; tick();
        lit("m_pend0", {16'd0, pending}, 24'h01);
        tick();
        lit("m_int_masked", {23'd0, interrupt}, 24'd0);
        mask_we = 1'b1; mask_wdata = 8'h00; tick();
        mask_we = 1'b0; tick();
        lit("m_int_unmask", {23'd0, interrupt}, 24'd1);
        lit("m_instr", interrupt_instruction, 24'hC70000);
        inta = 1'b1; tick();
        inta = 1'b0;

        // Channel 4 held against mask/priority changes, then aborted by reset.
        do_reset();
        irq_in = 8'h10; tick(); tick();
        lit("r_instr4", interrupt_instruction, 24'hE70000);
        irq_in = 8'h11; mask_we = 1'b1; mask_wdata = 8'hFF; tick();
        mask_we = 1'b0;
        lit("r_hold_active", {21'd0, active_ch}, 24'd4);
        lit("r_hold_int", {23'd0, interrupt}, 24'd1);
        rst = 1'b1; tick();
        rst = 1'b0;
        lit("r_abort_int", {23'd0, interrupt}, 24'd0);
        lit("r_abort_pend", {16'd0, pending}, 24'h00);
        lit("r_abort_instr", interrupt_instruction, 24'hFF0000);
        tick();
        lit("r_held_edge", {16'd0, pending}, 24'h11);
        tick();
        lit("r_after_instr", interrupt_instruction, 24'hC70000);
        irq_in = 8'h00; inta = 1'b1; tick();
        inta = 1'b0;

        // Quiet inputs with immediate acknowledge: timer-driven requests only.
        do_reset();
        first_rise = -1; second_rise = -1; rise_instr = 24'h0; prev_int = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            inta = interrupt;
            tick();
            if (interrupt && !prev_int) begin
                if (first_rise < 0) begin
                    first_rise = n;
                    rise_instr = interrupt_instruction;
                end else if (second_rise < 0) begin
                    second_rise = n;
                end
            end
            prev_int = interrupt;
        end
        inta = 1'b0;
`ifdef INTC_TIMER_EN
        lit("t_first", 24'(first_rise), 24'd13);
        lit("t_second", 24'(second_rise), 24'd25);
        lit("t_instr", rise_instr, 24'hFF0000);
`else
        lit("t_none", 24'(first_rise), 24'hFFFFFF);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            irq_in     = irq_in ^ (8'($urandom) & 8'($urandom));
            mask_we    = ($urandom_range(0, 7) == 0);
            mask_wdata = 8'($urandom) & 8'($urandom) & 8'($urandom);
            inta       = ($urandom_range(0, 2) == 0);
            rst        = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
